// File: rtl/vram_port_arbiter_pkg.sv
// rtl/vram_port_arbiter_pkg.sv - shared widths, slot encoding and limits for the VRAM arbiter
// Purpose: common definitions imported by vram_port_arbiter and vram_write_fifo.
// Contents: default address/data widths, RAM slot encoding, drop counter ceiling.
package vram_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 16;   // {y[7:0], x[7:0]}
  localparam int DEF_DATA_W = 3;    // R,G,B

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'b00,
    SLOT_READ  = 2'b01,
    SLOT_WRITE = 2'b10
  } slot_e;

  localparam logic [7:0] DROP_MAX = 8'd255;

endpackage

// File: rtl/vram_write_fifo.sv
// rtl/vram_write_fifo.sv - small write queue holding pending pixel writes
// Purpose: DEPTH-entry FIFO with registered pointers and occupancy count.
// Ports:
//   Clock, Reset   system clock, asynchronous active-high reset
//   push, din      enqueue din (caller guarantees room, or a same-cycle pop)
//   pop, dout      dequeue head; dout shows the current head
//   full, empty    occupancy flags derived from count
//   count          entries held, 0..DEPTH
module vram_write_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 19,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage carries no reset; discarding the queue only needs the pointers cleared.
  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/vram_port_arbiter.sv
// rtl/vram_port_arbiter.sv - single-port VRAM arbiter, display reads over queued writes
// Purpose: owns the VRAM pins; display fetches take every slot they ask for,
//          drawing writes are queued and issued in slots with no read.
// Ports:
//   Clock, Reset                  system clock, asynchronous active-high reset
//   iRdReq, iRdAddr               display fetch strobe and address
//   oRdData, oRdValid             fetched pixel two cycles after the request
//   iWrReq, iWrAddr, iWrData      drawing write request
//   oWrAck, oWrFull, oDropCount   write accepted, queue full, rejected-write count
//   oRamAddr, oRamWrData, oRamWe  registered RAM controls
//   iRamRdData                    RAM read data, one cycle after the address
module vram_port_arbiter
  import vram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WQ_DEPTH = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iRdReq,
  input  logic [ADDR_W-1:0] iRdAddr,
  output logic [DATA_W-1:0] oRdData,
  output logic              oRdValid,
  input  logic              iWrReq,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [DATA_W-1:0] iWrData,
  output logic              oWrAck,
  output logic              oWrFull,
  output logic [7:0]        oDropCount,
  output logic [ADDR_W-1:0] oRamAddr,
  output logic [DATA_W-1:0] oRamWrData,
  output logic              oRamWe,
  input  logic [DATA_W-1:0] iRamRdData
);

  localparam int CNT_W = $clog2(WQ_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WQ_DEPTH);

  slot_e                     slot;
  logic                      wq_push;
  logic                      wq_pop;
  logic                      wq_full;
  logic                      wq_empty;
  logic [CNT_W-1:0]          wq_count;
  logic [ADDR_W+DATA_W-1:0]  wq_head;
  logic [1:0]                rd_pipe;   // [0]: address on the RAM pins, [1]: data returning

  always_comb begin
    slot = SLOT_IDLE;
    if (iRdReq)         slot = SLOT_READ;
    else if (!wq_empty) slot = SLOT_WRITE;
  end

  assign wq_pop  = (slot == SLOT_WRITE);
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign wq_push = iWrReq && ((wq_count != FULL_CNT) || wq_pop);

  vram_write_fifo #(
    .DEPTH (WQ_DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_write_fifo (
    .Clock (Clock),
    .Reset (Reset),
    .push  (wq_push),
    .pop   (wq_pop),
    .din   ({iWrAddr, iWrData}),
    .dout  (wq_head),
    .full  (wq_full),
    .empty (wq_empty),
    .count (wq_count)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      oRamAddr   <= '0;
      oRamWrData <= '0;
      oRamWe     <= 1'b0;
      rd_pipe    <= 2'b00;
      oWrAck     <= 1'b0;
      oDropCount <= 8'd0;
    end else begin
      case (slot)
        SLOT_READ: begin
          oRamAddr <= iRdAddr;
          oRamWe   <= 1'b0;
        end
        SLOT_WRITE: begin
          oRamAddr   <= wq_head[ADDR_W+DATA_W-1:DATA_W];
          oRamWrData <= wq_head[DATA_W-1:0];
          oRamWe     <= 1'b1;
        end
        default: oRamWe <= 1'b0;
      endcase
      rd_pipe <= {rd_pipe[0], slot == SLOT_READ};
      oWrAck  <= wq_push;
      if (iWrReq && !wq_push && (oDropCount != DROP_MAX))
        oDropCount <= oDropCount + 8'd1;
    end
  end

  assign oRdValid = rd_pipe[1];
  assign oRdData  = rd_pipe[1] ? iRamRdData : '0;
  assign oWrFull  = wq_full;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb/tb_vram_port_arbiter.sv - self-checking bench for vram_port_arbiter
module tb_vram_port_arbiter;

  localparam int DEPTH = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        iRdReq = 1'b0;
  logic [15:0] iRdAddr = '0;
  logic [2:0]  oRdData;
  logic        oRdValid;
  logic        iWrReq = 1'b0;
  logic [15:0] iWrAddr = '0;
  logic [2:0]  iWrData = '0;
  logic        oWrAck;
  logic        oWrFull;
  logic [7:0]  oDropCount;
  logic [15:0] oRamAddr;
  logic [2:0]  oRamWrData;
  logic        oRamWe;
  logic [2:0]  iRamRdData = '0;

  vram_port_arbiter dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .iRdReq     (iRdReq),
    .iRdAddr    (iRdAddr),
    .oRdData    (oRdData),
    .oRdValid   (oRdValid),
    .iWrReq     (iWrReq),
    .iWrAddr    (iWrAddr),
    .iWrData    (iWrData),
    .oWrAck     (oWrAck),
    .oWrFull    (oWrFull),
    .oDropCount (oDropCount),
    .oRamAddr   (oRamAddr),
    .oRamWrData (oRamWrData),
    .oRamWe     (oRamWe),
    .iRamRdData (iRamRdData)
  );

  always #5 Clock = ~Clock;

  // Synchronous single-port RAM driven by the DUT pins.
  logic [2:0] ram [0:65535];
  always @(posedge Clock) begin
    iRamRdData <= ram[oRamAddr];
    if (oRamWe) ram[oRamAddr] <= oRamWrData;
  end

  // Reference model: pending-write queue, expected RAM image, read returns by due cycle.
  logic [2:0]  ref_mem [0:65535];
  logic [18:0] q[$];
  int          rq_due[$];
  logic [2:0]  rq_data[$];
  int          cyc = 0;
  logic [15:0] e_addr = '0;
  logic [2:0]  e_wd = '0;
  logic        e_we = 1'b0;
  logic        e_ack = 1'b0;
  logic [7:0]  e_drop = '0;
  logic        ev;
  logic [2:0]  ed;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic check_all();
    chk("ram_addr", 32'(oRamAddr), 32'(e_addr));
    chk("ram_wdata", 32'(oRamWrData), 32'(e_wd));
    chk("ram_we", 32'(oRamWe), 32'(e_we));
    chk("rd_valid", 32'(oRdValid), 32'(ev));
    chk("rd_data", 32'(oRdData), 32'(ed));
    chk("wr_ack", 32'(oWrAck), 32'(e_ack));
    chk("wr_full", 32'(oWrFull), 32'(q.size() == DEPTH));
    chk("drop_count", 32'(oDropCount), 32'(e_drop));
  endtask

  task automatic model_reset();
    q.delete();
    rq_due.delete();
    rq_data.delete();
    e_addr = '0; e_wd = '0; e_we = 1'b0; e_ack = 1'b0; e_drop = '0;
    ev = 1'b0; ed = '0;
  endtask

  // One clock cycle: drive inputs, predict, advance, check everything.
  task automatic step(input logic rd, input logic [15:0] ra, input logic wr,
                      input logic [15:0] wa, input logic [2:0] wd);
    logic        wslot;
    logic        acc;
    logic [18:0] ent;
    iRdReq = rd; iRdAddr = ra; iWrReq = wr; iWrAddr = wa; iWrData = wd;
    wslot = !rd && (q.size() > 0);
    acc   = wr && ((q.size() < DEPTH) || wslot);
    if (rd) begin
      e_addr = ra; e_we = 1'b0;
      rq_due.push_back(cyc + 2);
      rq_data.push_back(ref_mem[ra]);
    end else if (wslot) begin
      ent = q.pop_front();
      e_addr = ent[18:3]; e_wd = ent[2:0]; e_we = 1'b1;
      ref_mem[ent[18:3]] = ent[2:0];
    end else begin
      e_we = 1'b0;
    end
    if (acc) q.push_back({wa, wd});
    e_ack = acc;
    if (wr && !acc && e_drop != 8'd255) e_drop = e_drop + 8'd1;
    @(posedge Clock);
    #1;
    cyc++;
    if (rq_due.size() > 0 && rq_due[0] == cyc) begin
      ev = 1'b1;
      ed = rq_data.pop_front();
      void'(rq_due.pop_front());
    end else begin
      ev = 1'b0; ed = '0;
    end
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 1'b0, 16'h0, 3'b0);
  endtask

  initial begin
    int acks;
    int seen;
    logic prev_rd;
    logic rd;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 3'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[16'h1234] = 3'b101;
    ref_mem[16'h1234] = 3'b101;
    model_reset();

    // Reset, then idle
    repeat (2) @(posedge Clock);
    #1;
    check_all();
    Reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      idle();
      if (oRamWe) seen++;
    end
    chk("idle_we_seen", 32'(seen), 32'd0);

    // Single read, latency 2
    step(1'b1, 16'h1234, 1'b0, 16'h0, 3'b0);
    chk("rd_addr_n1", 32'(oRamAddr), 32'h1234);
    chk("rd_valid_n1", 32'(oRdValid), 32'd0);
    idle();
    chk("rd_valid_n2", 32'(oRdValid), 32'd1);
    chk("rd_data_n2", 32'(oRdData), 32'b101);
    idle();
    chk("rd_valid_n3", 32'(oRdValid), 32'd0);

    // Single write, issue two cycles after request
    step(1'b0, 16'h0, 1'b1, 16'h00FF, 3'b010);
    chk("wr_ack_n1", 32'(oWrAck), 32'd1);
    chk("wr_we_n1", 32'(oRamWe), 32'd0);
    idle();
    chk("wr_we_n2", 32'(oRamWe), 32'd1);
    chk("wr_addr_n2", 32'(oRamAddr), 32'h00FF);
    chk("wr_data_n2", 32'(oRamWrData), 32'b010);
    idle();

    // Reads held 8 cycles with 3 writes queued, writes drain in order afterwards
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 16'($urandom), i < 3, 16'h0100 + 16'(i), 3'(i + 1));
      if (oRamWe) seen++;
    end
    chk("we_during_reads", 32'(seen), 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("drain_we", 32'(oRamWe), 32'd1);
      chk("drain_addr", 32'(oRamAddr), 32'h0100 + 32'(i));
    end
    idle();
    idle();

    // Overflow: 6 writes while reads hold every slot
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 16'($urandom), 1'b1, 16'h0200 + 16'(i), 3'(i));
      if (oWrAck) acks++;
    end
    chk("ovf_acks", 32'(acks), 32'd4);
    chk("ovf_full", 32'(oWrFull), 32'd1);
    chk("ovf_drop", 32'(oDropCount), 32'd2);
    for (int i = 0; i < 300; i++)
      step(1'b1, 16'($urandom), 1'b1, 16'h0300, 3'b111);
    chk("drop_saturate", 32'(oDropCount), 32'd255);
    for (int i = 0; i < 6; i++) idle();
    chk("drained_full", 32'(oWrFull), 32'd0);

    // Reset with writes queued and a read in flight
    for (int i = 0; i < 3; i++)
      step(1'b1, 16'h1234, 1'b1, 16'h0400 + 16'(i), 3'(i + 4));
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge Clock);
    #1;
    cyc++;
    Reset = 1'b0;
    check_all();
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (oRamWe || oRdValid) seen++;
    end
    chk("post_reset_activity", 32'(seen), 32'd0);

    // Randomized traffic over a small address window to exercise hazards
    prev_rd = 1'b0;
    for (int i = 0; i < 500; i++) begin
      rd = !prev_rd && ($urandom_range(0, 9) < 4);
      step(rd, 16'h4000 | 16'($urandom_range(0, 15)),
           ($urandom_range(0, 9) < 5), 16'h4000 | 16'($urandom_range(0, 15)),
           3'($urandom));
      prev_rd = rd;
    end
    for (int i = 0; i < 8; i++) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_port_arbiter.md
# vram_port_arbiter

Arbitrates a single-port synchronous video RAM (256x256 pixels, 3-bit RGB) between the VGA display fetch path and a drawing requester, such as the keyboard-driven cursor painter. Display reads have strict priority because they are hard real-time. Writes are buffered in a small FIFO and issued in cycles with no read. The block sits between the VGA controller pixel path and the VRAM macro, and owns all RAM address/data/write-enable pins.

## Interface
- ADDR_W, 16, pixel address width ({y[7:0], x[7:0]})
- DATA_W, 3, pixel width (R,G,B)
- WQ_DEPTH, 4, write FIFO entries (power of two, >= 2)

- Clock  in  1  system clock; all logic on posedge
- Reset  in  1  Reset, asynchronous, active-high
- iRdReq  in  1  display fetch strobe, one cycle per pixel
- iRdAddr  in  ADDR_W  display fetch address
- oRdData  out  DATA_W  fetched pixel; 0 when oRdValid low
- oRdValid  out  1  oRdData valid this cycle
- iWrReq  in  1  write request strobe
- iWrAddr  in  ADDR_W  write address
- iWrData  in  DATA_W  write pixel
- oWrAck  out  1  write accepted into FIFO (registered)
- oWrFull  out  1  FIFO holds WQ_DEPTH entries
- oDropCount  out  8  writes rejected while full; saturates at 255
- oRamAddr  out  ADDR_W  RAM address (registered)
- oRamWrData  out  DATA_W  RAM write data (registered)
- oRamWe  out  1  RAM write enable (registered)
- iRamRdData  in  DATA_W  RAM read data, valid one cycle after address presented

## Operation
- Each cycle the slot is chosen from the current inputs: READ if iRdReq; else WRITE if FIFO non-empty; else IDLE. This is fixed priority with no write anti-starvation. The display guarantees at most one iRdReq every 2 cycles.
- READ: oRamAddr <= iRdAddr, oRamWe <= 0. Issue a valid token into a 2-stage pipeline.
- WRITE: pop the FIFO head. oRamAddr <= head addr, oRamWrData <= head data, oRamWe <= 1.
- IDLE: oRamWe <= 0. oRamAddr and oRamWrData hold.
- FIFO push on iWrReq when count < WQ_DEPTH, or when a pop occurs in the same cycle. With a simultaneous push and pop at full, count stays WQ_DEPTH and the push is accepted.
- iWrReq that is not accepted is dropped and oDropCount increments. There is no wrap: the counter saturates at 255.
- Writes issue in FIFO order. A read to an address with a pending queued write returns the old RAM contents; no forwarding.
- oRdData = iRamRdData gated by oRdValid.

## Timing
- Read latency: iRdReq in cycle N -> oRamAddr in N+1 -> oRdValid=1 and oRdData in N+2, for exactly 1 cycle. Back-to-back reads pipeline at 1 per cycle.
- Write: iWrReq accepted in cycle N -> oWrAck=1 in N+1. With the FIFO previously empty and no read in N+1, the RAM write (oRamWe=1) occurs in N+2.
- oWrFull is combinational from the FIFO count and reflects state after the last edge.
- Reset values: oRamAddr=0, oRamWrData=0, oRamWe=0, oRdValid=0, oRdData=0, oWrAck=0, oWrFull=0, oDropCount=0, FIFO empty.
- Reset mid-operation: queued writes are discarded. In-flight read tokens are cleared, so no oRdValid follows reset. Outputs return to reset values immediately (asynchronous).

## Structure
- Shared package: ADDR_W/DATA_W defaults; slot encoding SLOT_IDLE=2'b00, SLOT_READ=2'b01, SLOT_WRITE=2'b10; DROP_MAX=8'd255.
- Sub-module vram_write_fifo: WQ_DEPTH x (ADDR_W+DATA_W), registered pointers plus a count. Ports: push, pop, din, dout, full, empty, count. Simultaneous push and pop are legal at any occupancy.
- Top contains the slot selector, RAM output registers, read-valid pipeline and drop counter.

## Test plan
- Reset then idle 10 cycles -> all outputs 0, oRamWe never 1.
- iRdReq at addr 0x1234 in cycle N, RAM model returns 3'b101 -> oRamAddr=0x1234 in N+1; oRdValid=1, oRdData=3'b101 in N+2 only.
- Single iWrReq (0x00FF, 3'b010) with no reads -> oWrAck in N+1; oRamWe=1, oRamAddr=0x00FF, oRamWrData=3'b010 in N+2.
- iRdReq held every cycle for 8 cycles with 3 writes queued -> no oRamWe during reads. Writes issue in order in the 3 cycles after iRdReq drops.
- 6 writes in 6 consecutive cycles while reads block all slots (WQ_DEPTH=4) -> 4 acks, oWrFull=1, oDropCount=2. Then 300 more rejected writes -> oDropCount=255.
- Assert Reset with 3 writes queued and 1 read in flight -> no oRdValid and no oRamWe after reset; FIFO empty; oWrFull=0.
